// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: writeback-select codes, load funct3 codes,
// CSR addresses and memory-map region nibbles.
package wb_stage_pkg;

  localparam int          W_SIZE      = 32;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic [11:0] TOHOST_ADDR = 12'h51E;

  typedef enum logic [2:0] {
    PC_PLUS_4_W     = 3'd0,
    ALU_W           = 3'd1,
    DMEM_W          = 3'd2,
    UART_RX_W       = 3'd3,
    UART_STATUS_W   = 3'd4,
    BIOS_W          = 3'd5,
    CYCLE_COUNTER_W = 3'd6,
    INST_COUNTER_W  = 3'd7
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  localparam logic [3:0] REGION_DMEM_LO = 4'b0001;
  localparam logic [3:0] REGION_DMEM_HI = 4'b0011;
  localparam logic [3:0] REGION_BIOS    = 4'b0100;

endpackage

// File: rtl/wb_stage_if.sv
// XM->W pipeline inputs, memory/UART read data, w_logic controls and writeback outputs.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic              stall;
  logic              flush;
  logic [W_SIZE-1:0] pc_xm;
  logic [W_SIZE-1:0] inst_xm;
  logic [W_SIZE-1:0] alu_xm;
  logic [W_SIZE-1:0] rs1_xm;
  logic [W_SIZE-1:0] inst_w;
  logic [W_SIZE-1:0] dmem_dout;
  logic [W_SIZE-1:0] bios_dout;
  logic [7:0]        uart_rx_data;
  logic [1:0]        uart_status;
  logic [2:0]        WBSel;
  logic              RegWEn;
  logic              CSRWen;
  logic              CSRSel;
  logic              ResetCounters;
  logic [W_SIZE-1:0] wb_data;
  logic [4:0]        wb_rd;
  logic              wb_we;
  logic [W_SIZE-1:0] csr_tohost;

  modport master (
    output stall, flush, pc_xm, inst_xm, alu_xm, rs1_xm,
    output dmem_dout, bios_dout, uart_rx_data, uart_status,
    output WBSel, RegWEn, CSRWen, CSRSel, ResetCounters,
    input  inst_w, wb_data, wb_rd, wb_we, csr_tohost
  );

  modport slave (
    input  stall, flush, pc_xm, inst_xm, alu_xm, rs1_xm,
    input  dmem_dout, bios_dout, uart_rx_data, uart_status,
    input  WBSel, RegWEn, CSRWen, CSRSel, ResetCounters,
    output inst_w, wb_data, wb_rd, wb_we, csr_tohost
  );
endinterface

// File: rtl/wb_stage_load_formatter.sv
// Extracts a byte/half/word from a memory read word and sign- or zero-extends it.
module wb_stage_load_formatter
  import wb_stage_pkg::*;
(
  input  logic [W_SIZE-1:0] word,
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  output logic [W_SIZE-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Misaligned halves/words simply drop the low address bits.
  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LW:   result = word;
      F3_LBU:  result = {24'b0, byte_sel};
      F3_LHU:  result = {16'b0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: XM->W register, load formatting, writeback mux, cycle/instret counters
// and the tohost CSR.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  wb_stage_if.slave   bus
);

  logic              valid_w_reg;
  logic [W_SIZE-1:0] pc_w_reg;
  logic [W_SIZE-1:0] inst_w_reg;
  logic [W_SIZE-1:0] alu_w_reg;
  logic [W_SIZE-1:0] rs1_w_reg;
  logic [W_SIZE-1:0] cycle_cnt_reg;
  logic [W_SIZE-1:0] instret_cnt_reg;
  logic [W_SIZE-1:0] tohost_reg;
  logic [W_SIZE-1:0] wb_data_next;
  logic              tohost_write;

  // Index 0 formats DMEM, index 1 formats BIOS.
  logic [W_SIZE-1:0] src_word [2];
  logic [W_SIZE-1:0] fmt_word [2];

  assign src_word[0] = bus.dmem_dout;
  assign src_word[1] = bus.bios_dout;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fmt
      wb_stage_load_formatter u_fmt (
        .word   (src_word[gi]),
        .funct3 (inst_w_reg[14:12]),
        .offset (alu_w_reg[1:0]),
        .result (fmt_word[gi])
      );
    end
  endgenerate

  // Flush wins over stall so a squashed instruction never lingers in W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_w_reg <= 1'b0;
      pc_w_reg    <= '0;
      inst_w_reg  <= NOP_INST;
      alu_w_reg   <= '0;
      rs1_w_reg   <= '0;
    end else if (bus.flush) begin
      valid_w_reg <= 1'b0;
      pc_w_reg    <= '0;
      inst_w_reg  <= NOP_INST;
      alu_w_reg   <= '0;
      rs1_w_reg   <= '0;
    end else if (!bus.stall) begin
      valid_w_reg <= 1'b1;
      pc_w_reg    <= bus.pc_xm;
      inst_w_reg  <= bus.inst_xm;
      alu_w_reg   <= bus.alu_xm;
      rs1_w_reg   <= bus.rs1_xm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else if (bus.ResetCounters) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
      if (valid_w_reg && !bus.stall) begin
        instret_cnt_reg <= instret_cnt_reg + 1'b1;
      end
    end
  end

  assign tohost_write = bus.CSRWen && valid_w_reg && !bus.stall &&
                        (inst_w_reg[31:20] == TOHOST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost_reg <= '0;
    end else if (tohost_write) begin
      tohost_reg <= bus.CSRSel ? {27'b0, inst_w_reg[19:15]} : rs1_w_reg;
    end
  end

  always_comb begin
    wb_data_next = alu_w_reg;
    case (wb_sel_e'(bus.WBSel))
      PC_PLUS_4_W:     wb_data_next = pc_w_reg + 32'd4;
      ALU_W:           wb_data_next = alu_w_reg;
      DMEM_W:          wb_data_next = fmt_word[0];
      UART_RX_W:       wb_data_next = {24'b0, bus.uart_rx_data};
      UART_STATUS_W:   wb_data_next = {30'b0, bus.uart_status};
      BIOS_W:          wb_data_next = fmt_word[1];
      CYCLE_COUNTER_W: wb_data_next = cycle_cnt_reg;
      INST_COUNTER_W:  wb_data_next = instret_cnt_reg;
      default:         wb_data_next = alu_w_reg;
    endcase
  end

  assign bus.inst_w     = inst_w_reg;
  assign bus.wb_data    = wb_data_next;
  assign bus.wb_rd      = inst_w_reg[11:7];
  assign bus.wb_we      = bus.RegWEn && valid_w_reg && (inst_w_reg[11:7] != 5'd0);
  assign bus.csr_tohost = tohost_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage: reset, load formatting, writeback mux, counters,
// flush/stall, tohost CSR, x0 suppression and counter wrap.
module tb_wb_stage;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  wb_stage_if bus ();

  wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_xm(input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] alu, input logic [31:0] rs1);
    bus.pc_xm   = pc;
    bus.inst_xm = inst;
    bus.alu_xm  = alu;
    bus.rs1_xm  = rs1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 0; bus.flush = 0;
    drive_xm(32'h0, 32'h0000_0013, 32'h0, 32'h0);
    bus.dmem_dout = 0; bus.bios_dout = 0; bus.uart_rx_data = 0; bus.uart_status = 0;
    bus.WBSel = 3'd1; bus.RegWEn = 1'b1; bus.CSRWen = 0; bus.CSRSel = 0; bus.ResetCounters = 0;
    step();
    tests_run++;
    if (bus.inst_w !== 32'h0000_0013) begin
      tests_failed++; $display("FAIL reset_inst_w: got %h expected %h", bus.inst_w, 32'h13);
    end
    tests_run++;
    if (bus.wb_we !== 1'b0) begin
      tests_failed++; $display("FAIL reset_wb_we: got %b expected 0", bus.wb_we);
    end
    tests_run++;
    if (bus.csr_tohost !== 32'h0) begin
      tests_failed++; $display("FAIL reset_tohost: got %h expected 0", bus.csr_tohost);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset state checked");
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] dmem;
    logic [31:0] bios;
    logic [2:0]  sel;
    logic [31:0] exp;
  } load_vec_t;

  task automatic test_load_format();
    load_vec_t v [8];
    v[0] = '{32'h0000_8283, 32'h1000_0003, 32'h80FF_0000, 32'h1111_1111, 3'd2, 32'hFFFF_FF80}; // lb
    v[1] = '{32'h0000_D283, 32'h1000_0003, 32'h80FF_0000, 32'h1111_1111, 3'd2, 32'h0000_80FF}; // lhu
    v[2] = '{32'h0000_9283, 32'h1000_0002, 32'h80FF_0000, 32'h1111_1111, 3'd2, 32'hFFFF_80FF}; // lh
    v[3] = '{32'h0000_C283, 32'h1000_0002, 32'h80FF_1234, 32'h1111_1111, 3'd2, 32'h0000_00FF}; // lbu
    v[4] = '{32'h0000_A283, 32'h1000_0003, 32'h80FF_1234, 32'h1111_1111, 3'd2, 32'h80FF_1234}; // lw misaligned
    v[5] = '{32'h0000_9283, 32'h3000_0001, 32'h0000_F00D, 32'h1111_1111, 3'd2, 32'hFFFF_F00D}; // lh misaligned
    v[6] = '{32'h0000_8283, 32'h4000_0001, 32'h1234_5678, 32'h0000_7F00, 3'd5, 32'h0000_007F}; // lb bios
    v[7] = '{32'h0000_D283, 32'h4000_0002, 32'h1234_5678, 32'hBEEF_0000, 3'd5, 32'h0000_BEEF}; // lhu bios
    for (int i = 0; i < 8; i++) begin
      drive_xm(32'h0000_1000, v[i].inst, v[i].alu, 32'h0);
      step();
      bus.dmem_dout = v[i].dmem;
      bus.bios_dout = v[i].bios;
      bus.WBSel     = v[i].sel;
      #1;
      tests_run++;
      if (bus.wb_data !== v[i].exp) begin
        tests_failed++;
        $display("FAIL load_fmt[%0d]: got %h expected %h", i, bus.wb_data, v[i].exp);
      end
      $display("[TB] load vec %0d inst=%h alu=%h -> %h", i, v[i].inst, v[i].alu, bus.wb_data);
    end
  endtask

  task automatic test_wb_mux();
    drive_xm(32'h1000_0040, 32'h0010_0293, 32'h1234_5678, 32'h0);
    step();
    bus.uart_rx_data = 8'hA7;
    bus.uart_status  = 2'b10;
    bus.RegWEn       = 1'b1;
    bus.WBSel = 3'd0; #1;
    tests_run++;
    if (bus.wb_data !== 32'h1000_0044) begin
      tests_failed++; $display("FAIL mux_pc4: got %h expected %h", bus.wb_data, 32'h1000_0044);
    end
    bus.WBSel = 3'd1; #1;
    tests_run++;
    if (bus.wb_data !== 32'h1234_5678) begin
      tests_failed++; $display("FAIL mux_alu: got %h expected %h", bus.wb_data, 32'h1234_5678);
    end
    bus.WBSel = 3'd3; #1;
    tests_run++;
    if (bus.wb_data !== 32'h0000_00A7) begin
      tests_failed++; $display("FAIL mux_uart_rx: got %h expected %h", bus.wb_data, 32'hA7);
    end
    bus.WBSel = 3'd4; #1;
    tests_run++;
    if (bus.wb_data !== 32'h0000_0002) begin
      tests_failed++; $display("FAIL mux_uart_status: got %h expected %h", bus.wb_data, 32'h2);
    end
    tests_run++;
    if (bus.wb_rd !== 5'd5 || bus.wb_we !== 1'b1) begin
      tests_failed++; $display("FAIL mux_rd_we: got rd=%0d we=%b expected rd=5 we=1", bus.wb_rd, bus.wb_we);
    end
    $display("[TB] writeback mux checked");
  endtask

  task automatic test_counters();
    drive_xm(32'h0000_2000, 32'h0010_0293, 32'h0, 32'h0);
    bus.stall = 0; bus.flush = 0;
    bus.ResetCounters = 1'b1;
    step();
    bus.ResetCounters = 1'b0;
    for (int i = 0; i < 13; i++) begin
      bus.stall = (i >= 4 && i < 7);
      bus.pc_xm = 32'h0000_2000 + 32'(4 * i);
      step();
    end
    bus.stall = 1'b0;
    bus.WBSel = 3'd6; #1;
    tests_run++;
    if (bus.wb_data !== 32'd13) begin
      tests_failed++; $display("FAIL cycle_cnt: got %0d expected 13", bus.wb_data);
    end
    bus.WBSel = 3'd7; #1;
    tests_run++;
    if (bus.wb_data !== 32'd10) begin
      tests_failed++; $display("FAIL instret_cnt: got %0d expected 10", bus.wb_data);
    end
    bus.ResetCounters = 1'b1;
    step();
    bus.ResetCounters = 1'b0;
    bus.WBSel = 3'd6; #1;
    tests_run++;
    if (bus.wb_data !== 32'd0) begin
      tests_failed++; $display("FAIL cycle_clear: got %0d expected 0", bus.wb_data);
    end
    bus.WBSel = 3'd7; #1;
    tests_run++;
    if (bus.wb_data !== 32'd0) begin
      tests_failed++; $display("FAIL instret_clear: got %0d expected 0", bus.wb_data);
    end
    $display("[TB] counters checked");
  endtask

  task automatic test_flush_stall();
    // instret is 0 after the clear; this edge retires the instruction held in W.
    drive_xm(32'h0000_3000, 32'h0030_0313, 32'h3, 32'h0);
    bus.RegWEn = 1'b1;
    step();
    bus.flush = 1'b1; bus.stall = 1'b1;
    step();
    bus.WBSel = 3'd7; #1;
    tests_run++;
    if (bus.inst_w !== 32'h0000_0013 || bus.wb_we !== 1'b0) begin
      tests_failed++; $display("FAIL flush_bubble: got inst=%h we=%b expected inst=00000013 we=0", bus.inst_w, bus.wb_we);
    end
    tests_run++;
    if (bus.wb_data !== 32'd1) begin
      tests_failed++; $display("FAIL flush_instret: got %0d expected 1", bus.wb_data);
    end
    bus.flush = 1'b0; bus.stall = 1'b0;
    step();
    #1;
    tests_run++;
    if (bus.wb_data !== 32'd1 || bus.wb_we !== 1'b1) begin
      tests_failed++; $display("FAIL bubble_not_counted: got instret=%0d we=%b expected 1 1", bus.wb_data, bus.wb_we);
    end
    $display("[TB] flush/stall checked");
  endtask

  task automatic test_csr();
    bus.RegWEn = 1'b0;
    drive_xm(32'h0000_4000, 32'h51E2_D073, 32'h0, 32'h0);
    step();
    bus.CSRWen = 1'b1; bus.CSRSel = 1'b1;
    drive_xm(32'h0000_4004, 32'h0000_0013, 32'h0, 32'h0);
    step();
    bus.CSRWen = 1'b0;
    tests_run++;
    if (bus.csr_tohost !== 32'd5) begin
      tests_failed++; $display("FAIL csrwi_tohost: got %h expected %h", bus.csr_tohost, 32'd5);
    end
    drive_xm(32'h0000_4008, 32'h51E0_9073, 32'h0, 32'hDEAD_BEEF);
    step();
    bus.CSRWen = 1'b1; bus.CSRSel = 1'b0; bus.stall = 1'b1;
    step();
    tests_run++;
    if (bus.csr_tohost !== 32'd5) begin
      tests_failed++; $display("FAIL csr_stalled: got %h expected %h", bus.csr_tohost, 32'd5);
    end
    bus.stall = 1'b0;
    step();
    bus.CSRWen = 1'b0;
    tests_run++;
    if (bus.csr_tohost !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL csrw_tohost: got %h expected %h", bus.csr_tohost, 32'hDEAD_BEEF);
    end
    drive_xm(32'h0000_400C, 32'h3400_9073, 32'h0, 32'h1234_5678);
    step();
    bus.CSRWen = 1'b1;
    step();
    bus.CSRWen = 1'b0;
    tests_run++;
    if (bus.csr_tohost !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL csr_other_addr: got %h expected %h", bus.csr_tohost, 32'hDEAD_BEEF);
    end
    $display("[TB] tohost CSR checked");
  endtask

  task automatic test_x0_and_wrap();
    drive_xm(32'h0000_5000, 32'h0050_0013, 32'h5, 32'h0);
    bus.RegWEn = 1'b1;
    step();
    tests_run++;
    if (bus.wb_we !== 1'b0 || bus.wb_rd !== 5'd0) begin
      tests_failed++; $display("FAIL x0_write: got we=%b rd=%0d expected we=0 rd=0", bus.wb_we, bus.wb_rd);
    end
    bus.stall = 1'b1;
    force dut.instret_cnt_reg = 32'hFFFF_FFFF;
    #1;
    release dut.instret_cnt_reg;
    bus.WBSel = 3'd7; #1;
    tests_run++;
    if (bus.wb_data !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL instret_preload: got %h expected %h", bus.wb_data, 32'hFFFF_FFFF);
    end
    bus.stall = 1'b0;
    step();
    tests_run++;
    if (bus.wb_data !== 32'h0) begin
      tests_failed++; $display("FAIL instret_wrap: got %h expected 0", bus.wb_data);
    end
    $display("[TB] x0 suppression and wrap checked");
  endtask

  task automatic test_midstream_reset();
    drive_xm(32'h0000_6000, 32'h0010_0293, 32'h1, 32'h0);
    bus.RegWEn = 1'b1;
    step();
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.inst_w !== 32'h0000_0013 || bus.wb_we !== 1'b0) begin
      tests_failed++; $display("FAIL async_rst_w: got inst=%h we=%b expected 00000013 0", bus.inst_w, bus.wb_we);
    end
    tests_run++;
    if (bus.csr_tohost !== 32'h0) begin
      tests_failed++; $display("FAIL async_rst_tohost: got %h expected 0", bus.csr_tohost);
    end
    bus.WBSel = 3'd6; #1;
    tests_run++;
    if (bus.wb_data !== 32'h0) begin
      tests_failed++; $display("FAIL async_rst_cycle: got %h expected 0", bus.wb_data);
    end
    bus.WBSel = 3'd7; #1;
    tests_run++;
    if (bus.wb_data !== 32'h0) begin
      tests_failed++; $display("FAIL async_rst_instret: got %h expected 0", bus.wb_data);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.WBSel = 3'd6;
    step();
    tests_run++;
    if (bus.wb_data !== 32'd1) begin
      tests_failed++; $display("FAIL cycle_after_rst: got %0d expected 1", bus.wb_data);
    end
    $display("[TB] mid-stream reset checked");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_load_format();
    test_wb_mux();
    test_counters();
    test_flush_stall();
    test_csr();
    test_x0_and_wrap();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
